// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the multi-port register file.
//   ecall_state_t : system-call handshake FSM states
//   REG_*         : architectural register indices used by the register file
//   SYS_NARGS     : number of argument registers (a0..a7) handed to the handler
package regfile_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    REQ,
    RESP,
    DONE
  } ecall_state_t;

  localparam int unsigned REG_ZERO  = 0;
  localparam int unsigned REG_SP    = 2;
  localparam int unsigned REG_A0    = 10;
  localparam int unsigned REG_A7    = 17;
  localparam int unsigned SYS_NARGS = REG_A7 - REG_A0 + 1;

endpackage

// File: rtl/regfile_ecall_fsm.sv
// regfile_ecall_fsm: sequencing of the system-call channel.
//   clk, reset       : clock, synchronous active-high reset
//   ecall            : request level from the pipeline
//   any_busy         : OR of all scoreboard busy bits
//   any_wr           : OR of all write-port enables
//   sys_ready        : handler accepts the argument bundle
//   sys_resp_valid   : handler result valid
//   sys_valid        : argument bundle valid (state REQ)
//   ecall_done       : call complete (state DONE)
//   capture          : snapshot a0..a7 into the argument bundle on this edge
//   a0_write         : write the handler result into a0 on this edge
module regfile_ecall_fsm
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ecall,
  input  logic any_busy,
  input  logic any_wr,
  input  logic sys_ready,
  input  logic sys_resp_valid,
  output logic sys_valid,
  output logic ecall_done,
  output logic capture,
  output logic a0_write
);

  ecall_state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    sys_valid  = 1'b0;
    ecall_done = 1'b0;
    capture    = 1'b0;
    a0_write   = 1'b0;
    case (state)
      IDLE:  if (ecall) state_next = DRAIN;
      DRAIN: begin
        // Abort takes precedence over a drain that completes in the same cycle.
        if (!ecall) begin
          state_next = IDLE;
        end else if (!any_busy && !any_wr) begin
          state_next = REQ;
          capture    = 1'b1;
        end
      end
      REQ: begin
        // ecall is deliberately ignored here so sys_valid cannot retract.
        sys_valid = 1'b1;
        if (sys_ready) state_next = RESP;
      end
      RESP: begin
        if (sys_resp_valid) begin
          state_next = DONE;
          a0_write   = 1'b1;
        end
      end
      DONE: begin
        ecall_done = 1'b1;
        if (!ecall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/multiport_regfile.sv
// multiport_regfile: parametrised integer register file with NRD combinational
// read ports, NWR write ports (highest index wins), a per-register busy
// scoreboard and a handshaked system-call channel on a0..a7.
//   clk, reset             : clock, synchronous active-high reset
//   stackptr               : reset value of x[SP_IDX]
//   rd_addr/rd_data/rd_busy: read ports (port i at [i*AW +: AW] / [i*XLEN +: XLEN])
//   wr_en/wr_addr/wr_data  : write ports
//   claim_en/claim_addr    : issue-side destination claim (sets busy)
//   ecall/ecall_done       : pipeline system-call request / completion
//   sys_valid/sys_ready/sys_args           : argument bundle handshake
//   sys_resp_valid/sys_resp_data           : handler result into a0
// Build option: REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned SP_IDX = REG_SP,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [XLEN-1:0]           stackptr,
  input  logic [NRD*AW-1:0]         rd_addr,
  output logic [NRD*XLEN-1:0]       rd_data,
  output logic [NRD-1:0]            rd_busy,
  input  logic [NWR-1:0]            wr_en,
  input  logic [NWR*AW-1:0]         wr_addr,
  input  logic [NWR*XLEN-1:0]       wr_data,
  input  logic                      claim_en,
  input  logic [AW-1:0]             claim_addr,
  input  logic                      ecall,
  output logic                      ecall_done,
  output logic                      sys_valid,
  input  logic                      sys_ready,
  output logic [SYS_NARGS*XLEN-1:0] sys_args,
  input  logic                      sys_resp_valid,
  input  logic [XLEN-1:0]           sys_resp_data
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);
  localparam logic [AW-1:0] SP_ADDR   = AW'(SP_IDX);
  localparam logic [AW-1:0] A0_ADDR   = AW'(REG_A0);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;
  logic                       capture;
  logic                       a0_write;
  logic                       any_busy;
  logic                       any_wr;

  assign any_busy = |busy;
  assign any_wr   = |wr_en;

  regfile_ecall_fsm u_ecall_fsm (
    .clk            (clk),
    .reset          (reset),
    .ecall          (ecall),
    .any_busy       (any_busy),
    .any_wr         (any_wr),
    .sys_ready      (sys_ready),
    .sys_resp_valid (sys_resp_valid),
    .sys_valid      (sys_valid),
    .ecall_done     (ecall_done),
    .capture        (capture),
    .a0_write       (a0_write)
  );

  // Later assignments in this block override earlier ones: ascending port
  // order gives highest-port priority, the handler result overrides any port
  // writing a0, and a claim overrides the busy-clear of a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs          <= '0;
      regs[SP_ADDR] <= stackptr;
      busy          <= '0;
      sys_args      <= '0;
    end else begin
      for (int unsigned w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] != ZERO_ADDR) begin
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
          busy[wr_addr[w*AW +: AW]] <= 1'b0;
        end
      end
      if (a0_write) begin
        regs[A0_ADDR] <= sys_resp_data;
        busy[A0_ADDR] <= 1'b0;
      end
      if (claim_en && claim_addr != ZERO_ADDR) busy[claim_addr] <= 1'b1;
      if (capture) begin
        for (int unsigned k = 0; k < SYS_NARGS; k++) begin
          sys_args[k*XLEN +: XLEN] <= regs[AW'(REG_A0 + k)];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      rd_data[p*XLEN +: XLEN] = (rd_addr[p*AW +: AW] == ZERO_ADDR) ? '0 : regs[rd_addr[p*AW +: AW]];
      rd_busy[p]              = busy[rd_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW] &&
            rd_addr[p*AW +: AW] != ZERO_ADDR) begin
          rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
          rd_busy[p]              = claim_en && (claim_addr == rd_addr[p*AW +: AW]);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_multiport_regfile.sv
module tb_multiport_regfile;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  stackptr;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_busy;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;
  logic         claim_en;
  logic [4:0]   claim_addr;
  logic         ecall;
  logic         ecall_done;
  logic         sys_valid;
  logic         sys_ready;
  logic [511:0] sys_args;
  logic         sys_resp_valid;
  logic [63:0]  sys_resp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiport_regfile #(.XLEN(64), .NREGS(32), .NRD(2), .NWR(2), .SP_IDX(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .stackptr       (stackptr),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_busy        (rd_busy),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .claim_en       (claim_en),
    .claim_addr     (claim_addr),
    .ecall          (ecall),
    .ecall_done     (ecall_done),
    .sys_valid      (sys_valid),
    .sys_ready      (sys_ready),
    .sys_args       (sys_args),
    .sys_resp_valid (sys_resp_valid),
    .sys_resp_data  (sys_resp_data)
  );

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural state updated once per clock from the rules.
  typedef enum int {S_IDLE, S_DRAIN, S_REQ, S_RESP, S_DONE} mstate_t;
  logic [63:0]  m_regs [32];
  logic [31:0]  m_busy;
  logic [511:0] m_args;
  mstate_t      m_st;
  bit           m_ok = 1'b0;

  always @(posedge clk) begin : model
    logic [511:0] snap;
    logic         quiet;
    if (reset) begin
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_regs[2] = stackptr;
      m_busy    = '0;
      m_args    = '0;
      m_st      = S_IDLE;
      m_ok      = 1'b1;
    end else if (m_ok) begin
      for (int k = 0; k < 8; k++) snap[k*64 +: 64] = m_regs[10+k];
      quiet = (m_busy == 32'd0) && (wr_en == 2'b00);
      for (int w = 0; w < 2; w++) begin
        if (wr_en[w] && wr_addr[w*5 +: 5] != 5'd0) begin
          m_regs[wr_addr[w*5 +: 5]] = wr_data[w*64 +: 64];
          m_busy[wr_addr[w*5 +: 5]] = 1'b0;
        end
      end
      case (m_st)
        S_IDLE:  if (ecall) m_st = S_DRAIN;
        S_DRAIN: if (!ecall) m_st = S_IDLE;
                 else if (quiet) begin m_args = snap; m_st = S_REQ; end
        S_REQ:   if (sys_ready) m_st = S_RESP;
        S_RESP:  if (sys_resp_valid) begin
                   m_regs[10] = sys_resp_data;
                   m_busy[10] = 1'b0;
                   m_st = S_DONE;
                 end
        S_DONE:  if (!ecall) m_st = S_IDLE;
        default: m_st = S_IDLE;
      endcase
      if (claim_en && claim_addr != 5'd0) m_busy[claim_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    logic [4:0]  a;
    logic [63:0] ed;
    logic        eb;
    if (m_ok) begin
      for (int p = 0; p < 2; p++) begin
        a  = rd_addr[p*5 +: 5];
        ed = (a == 5'd0) ? 64'd0 : m_regs[a];
        eb = m_busy[a];
        if (BYP) begin
          for (int w = 0; w < 2; w++) begin
            if (wr_en[w] && wr_addr[w*5 +: 5] == a && a != 5'd0) begin
              ed = wr_data[w*64 +: 64];
              eb = claim_en && claim_addr == a;
            end
          end
        end
        chk("rd_data", 512'(rd_data[p*64 +: 64]), 512'(ed));
        chk("rd_busy", 512'(rd_busy[p]), 512'(eb));
      end
      chk("sys_valid", 512'(sys_valid), 512'(m_st == S_REQ));
      chk("ecall_done", 512'(ecall_done), 512'(m_st == S_DONE));
      chk("sys_args", sys_args, m_args);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wr_en          = '0;
    claim_en       = 1'b0;
    sys_ready      = 1'b0;
    sys_resp_valid = 1'b0;
  endtask

  task automatic setw(input int p, input logic [4:0] a, input logic [63:0] d);
    wr_en[p]          = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*64 +: 64] = d;
  endtask

  task automatic setr(input int p, input logic [4:0] a);
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!sys_valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; stackptr = 64'h8000_0000;
    rd_addr = '0; wr_addr = '0; wr_data = '0; claim_addr = '0;
    ecall = 1'b0; sys_resp_data = '0;
    clr();
    tick(); tick();
    reset = 1'b0;

    // Reset state of every register
    for (int r = 0; r < 32; r++) begin
      setr(0, 5'(r)); setr(1, 5'(31 - r));
      #1;
      chk("reset_reg", 512'(rd_data[63:0]), (r == 2) ? 512'h8000_0000 : 512'd0);
      chk("reset_busy", 512'(rd_busy), 512'd0);
      tick();
    end
    chk("reset_sys_valid", 512'(sys_valid), 512'd0);
    chk("reset_sys_args", sys_args, 512'd0);

    // Write-port conflict and x0
    setw(0, 5, 64'h11); setw(1, 5, 64'h22); setr(0, 5);
    #1 chk("conflict_same_cycle", 512'(rd_data[63:0]), BYP ? 512'h22 : 512'd0);
    tick(); clr();
    #1 chk("conflict_winner", 512'(rd_data[63:0]), 512'h22);
    setw(0, 0, 64'hFF); setr(0, 0);
    tick(); clr();
    #1 chk("x0_write_ignored", 512'(rd_data[63:0]), 512'd0);

    // Scoreboard
    claim_en = 1'b1; claim_addr = 7; setr(0, 7);
    #1 chk("claim_before_edge", 512'(rd_busy[0]), 512'd0);
    tick(); clr();
    #1 chk("claim_busy", 512'(rd_busy[0]), 512'd1);
    setw(0, 7, 64'h77);
    #1 chk("write_busy_same_cycle", 512'(rd_busy[0]), BYP ? 512'd0 : 512'd1);
    tick(); clr();
    #1 chk("write_clears_busy", 512'(rd_busy[0]), 512'd0);
    chk("write_x7", 512'(rd_data[63:0]), 512'h77);
    claim_en = 1'b1; claim_addr = 9; setw(1, 9, 64'h99);
    tick(); clr(); setr(1, 9);
    #1 chk("claim_beats_write", 512'(rd_busy[1]), 512'd1);
    chk("claim_write_data", 512'(rd_data[127:64]), 512'h99);
    setw(0, 9, 64'h9A);
    tick(); clr();
    #1 chk("x9_released", 512'(rd_busy[1]), 512'd0);

    // Bypass
    setw(0, 3, 64'hABC); setr(0, 3);
    #1 chk("bypass_same_cycle", 512'(rd_data[63:0]), BYP ? 512'hABC : 512'd0);
    tick(); clr();
    #1 chk("bypass_next_cycle", 512'(rd_data[63:0]), 512'hABC);

    // Ecall with a drain on x4
    setw(0, 10, 64'd1); setw(1, 17, 64'd64);
    tick(); clr();
    claim_en = 1'b1; claim_addr = 4;
    tick(); clr();
    ecall = 1'b1;
    tick();
    repeat (3) begin
      #1 chk("drain_hold", 512'(sys_valid), 512'd0);
      tick();
    end
    setw(0, 4, 64'h44);
    #1 chk("drain_write_cycle", 512'(sys_valid), 512'd0);
    tick(); clr();
    wait_valid(8, n);
    chk("drain_exit_latency", 512'(n), 512'd1);
    chk("ecall_valid", 512'(sys_valid), 512'd1);
    chk("args_a0", 512'(sys_args[63:0]), 512'd1);
    chk("args_a7", 512'(sys_args[7*64 +: 64]), 512'd64);
    tick();
    ecall = 1'b0;
    tick();
    ecall = 1'b1;
    tick();
    #1 chk("req_stable_valid", 512'(sys_valid), 512'd1);
    chk("req_stable_a0", 512'(sys_args[63:0]), 512'd1);
    sys_ready = 1'b1;
    tick(); clr();
    #1 chk("resp_valid_low", 512'(sys_valid), 512'd0);
    tick();
    sys_resp_valid = 1'b1; sys_resp_data = 64'h2A; setw(1, 10, 64'h55);
    tick(); clr(); setr(0, 10);
    #1 chk("ecall_done", 512'(ecall_done), 512'd1);
    chk("a0_result", 512'(rd_data[63:0]), 512'h2A);
    ecall = 1'b0;
    tick();
    #1 chk("done_to_idle", 512'(ecall_done), 512'd0);

    // Reset in the middle of a call
    ecall = 1'b1;
    wait_valid(8, n);
    chk("idle_to_req_latency", 512'(n), 512'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0; ecall = 1'b0;
    #1 chk("reset_mid_valid", 512'(sys_valid), 512'd0);
    sys_resp_valid = 1'b1; sys_resp_data = 64'h99;
    tick(); clr(); setr(0, 10); setr(1, 2);
    #1 chk("reset_mid_a0", 512'(rd_data[63:0]), 512'd0);
    chk("reset_mid_sp", 512'(rd_data[127:64]), 512'h8000_0000);
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rd_addr        = 10'($urandom);
      wr_en          = 2'($urandom);
      wr_addr        = 10'($urandom);
      wr_data        = {$urandom, $urandom, $urandom, $urandom};
      claim_en       = ($urandom_range(0, 7) == 0);
      claim_addr     = 5'($urandom);
      if ($urandom_range(0, 15) == 0) ecall = ~ecall;
      sys_ready      = $urandom_range(0, 1) == 1;
      sys_resp_valid = $urandom_range(0, 3) == 0;
      sys_resp_data  = {$urandom, $urandom};
      reset          = ($urandom_range(0, 499) == 0);
      if (reset) stackptr = {$urandom, $urandom};
      tick();
    end
    reset = 1'b0; clr();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
# multiport_regfile

Parametrised integer register file for the core: configurable register count, width, read ports and write ports, plus a per-register busy scoreboard and a handshaked system-call channel. The system-call channel snapshots a0–a7, hands them to an external handler and writes the result back to a0. It replaces the single-write-port register file and sits between decode/issue (reads, claims) and writeback (writes).

## Interface
- `XLEN`, 64, register width
- `NREGS`, 32, number of architectural registers (power of two, ≥ 18); `AW = $clog2(NREGS)`
- `NRD`, 2, read ports
- `NWR`, 2, write ports
- `SP_IDX`, 2, register loaded from `stackptr` at reset
- `clk  in  1  clock`
- `reset  in  1  reset, synchronous, active-high; clock clk`
- `stackptr  in  XLEN  reset value for x[SP_IDX]`
- `rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]`
- `rd_data  out  NRD*XLEN  read data`
- `rd_busy  out  NRD  busy bit of each addressed register`
- `wr_en  in  NWR  write enables`
- `wr_addr  in  NWR*AW  write addresses`
- `wr_data  in  NWR*XLEN  write data`
- `claim_en  in  1  issue claims a destination register (sets busy)`
- `claim_addr  in  AW  claimed register`
- `ecall  in  1  system-call request level from the pipeline; held until ecall_done`
- `ecall_done  out  1  system call complete`
- `sys_valid  out  1  argument bundle valid`
- `sys_ready  in  1  handler accepts the bundle`
- `sys_args  out  8*XLEN  snapshot of x10..x17; a0 is at bits [XLEN-1:0]`
- `sys_resp_valid  in  1  handler result valid (one-cycle pulse)`
- `sys_resp_data  in  XLEN  result written to a0`

## Operation
- x0 reads 0. Writes and claims to x0 are ignored.
- **Write ports:** when several enabled ports target the same register in one cycle, the highest-index port wins.
- **Scoreboard:** a claim sets `busy[claim_addr]`; any write to a register clears its busy bit.
  - Claim and write to the same register in one cycle: the claim wins, so busy stays 1.
- **Read ports:** combinational from the register array. `rd_busy` reflects the busy bits before this cycle's updates.
- **Ecall FSM** has states IDLE, DRAIN, REQ, RESP, DONE.
  - IDLE → DRAIN when `ecall` = 1.
  - DRAIN → REQ when all busy bits are 0 and no write is enabled this cycle. x10..x17 are captured into `sys_args` on this edge.
  - DRAIN → IDLE if `ecall` drops (abort).
  - REQ: `sys_valid` = 1 and `sys_args` stays stable. `ecall` dropping here is ignored. REQ → RESP on `sys_valid && sys_ready`.
  - RESP → DONE on `sys_resp_valid`. a0 ← `sys_resp_data` on that edge, overriding any write port targeting x10 in the same cycle, and `busy[10]` is cleared.
  - DONE: `ecall_done` = 1. DONE → IDLE when `ecall` = 0.
- **Reset:** all registers are 0 except x[SP_IDX] = `stackptr`; all busy bits 0; FSM in IDLE. `sys_valid`, `ecall_done`, `sys_args` and `rd_busy` of idle ports are 0.
  - Reset mid-call aborts the call; a pending `sys_resp_valid` is discarded.

## Timing
- Reads: 0-cycle combinational.
- Writes: visible on reads the cycle after the edge, or in the same cycle with `REGFILE_BYPASS_EN`.
- Ecall with an empty scoreboard: `ecall` high at cycle 0 → DRAIN at 1 → REQ (`sys_valid`) at 2.
  - With `sys_ready` already high, RESP at 3. `sys_resp_valid` at cycle k puts DONE and the new a0 at k+1.
- `sys_valid` never deasserts without a handshake, except on reset.

## Configuration
- **`REGFILE_BYPASS_EN` defined:** a read whose address matches an enabled write port returns that write's data in the same cycle. The highest-index matching port is used, and x0 is never bypassed. `rd_busy` for that port reads 0 unless a same-cycle claim hits the same register.
- **Undefined:** reads return array contents only; same-cycle writes are invisible.

## Structure
- **Package `regfile_pkg`:**
  - typedef `ecall_state_t` (enum IDLE, DRAIN, REQ, RESP, DONE)
  - constants `REG_ZERO` = 0, `REG_SP` = 2, `REG_A0` = 10, `REG_A7` = 17, `SYS_NARGS` = 8
- **Sub-module `regfile_ecall_fsm`:** the state register, transitions and `sys_valid`/`ecall_done`. Inputs are `ecall`, the OR of the busy bits and the OR of `wr_en`. Outputs are the capture strobe and the a0-write strobe.
- The array, scoreboard and port arbitration stay in the top module.

## Test plan
- **Reset:** reset with `stackptr` = 0x8000_0000 → x2 reads 0x8000_0000, every other register reads 0, all `rd_busy` 0, `sys_valid` = 0.
- **Write conflict:** port0 writes x5 = 0x11 and port1 writes x5 = 0x22 in the same cycle → x5 = 0x22 next cycle; a write of 0xFF to x0 → x0 reads 0.
- **Scoreboard:** claim x7, then write x7 → `rd_busy` is 1 one cycle after the claim and 0 after the write; claim and write x9 in the same cycle → busy stays 1.
- **Bypass:** write x3 = 0xABC while reading x3 → `rd_data` = 0xABC in the same cycle with `REGFILE_BYPASS_EN`, previous value without it.
- **Ecall:** preload a0 = 1 and a7 = 64, hold x4 busy, raise `ecall` → stays in DRAIN until x4 is written. Then `sys_valid` rises with `sys_args[XLEN-1:0]` = 1. `sys_ready` held low 3 cycles keeps args stable. `sys_resp_data` = 0x2A → a0 = 0x2A and `ecall_done` = 1; dropping `ecall` → IDLE.
- **Reset mid-call:** reset asserted in REQ → `sys_valid` = 0 after the edge and FSM in IDLE; a later `sys_resp_valid` leaves a0 = 0.
